// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth digit sequencer: FSM states and the
// sign/magnitude flags that describe one recoded digit.
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Combinational radix-4 Booth encoder: one triplet (b[2i+1], b[2i], b[2i-1])
// in, sign/magnitude flags and the signed digit value out.
module booth_r4_digit_enc
    import booth_pkg::*;
(
    input  logic              [2:0] triplet_i,
    output booth_digit_t            digit_o,
    output logic signed       [2:0] value_o
);

    // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        digit_o.one = triplet_i[1] ^ triplet_i[0];
        digit_o.two = (triplet_i == 3'b100) || (triplet_i == 3'b011);
        digit_o.neg = triplet_i[2] & ~(triplet_i[1] & triplet_i[0]);
        value_o     = 3'sd0;
        case (triplet_i)
            3'b001, 3'b010: value_o = 3'sd1;
            3'b011:         value_o = 3'sd2;
            3'b100:         value_o = -3'sd2;
            3'b101, 3'b110: value_o = -3'sd1;
            default:        value_o = 3'sd0;
        endcase
    end

endmodule

// File: rtl/booth_r4_enc_seq.sv
// Sequential radix-4 Booth recoder: captures a signed multiplier operand and
// streams its WIDTH/2 digits, least significant first, over a valid/ready port.
module booth_r4_enc_seq
    import booth_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int TRUNC_DIGITS = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_neg,
    output logic                             out_one,
    output logic                             out_two,
    output logic signed [2:0]                out_digit,
    output logic [$clog2(WIDTH/2)-1:0]       out_idx,
    output logic                             out_last
);

    localparam int                N        = WIDTH / 2;
    localparam int                IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    booth_digit_t        dig_q, dig_d;
    logic signed [2:0]   val_q, val_d;
    logic                last_q, last_d;

    // The single encoder looks one digit ahead: in IDLE it sees digit 0 of the
    // incoming operand, in RUN the digit after the one currently presented.
    logic [WIDTH-1:0]    enc_src;
    logic [IDX_W-1:0]    enc_idx;
    logic [WIDTH:0]      enc_ext;
    logic [WIDTH:0]      enc_shift;
    logic [2:0]          enc_triplet;
    booth_digit_t        enc_dig;
    logic signed [2:0]   enc_val;
    logic                enc_kill;
    booth_digit_t        nxt_dig;
    logic signed [2:0]   nxt_val;

    always_comb begin
        enc_src     = (state_q == IDLE) ? in_b : opnd_q;
        enc_idx     = (state_q == IDLE) ? '0 : idx_q + IDX_W'(1);
        enc_ext     = {enc_src, 1'b0};
        enc_shift   = enc_ext >> {enc_idx, 1'b0};
        enc_triplet = enc_shift[2:0];
    end

    booth_r4_digit_enc u_enc (
        .triplet_i (enc_triplet),
        .digit_o   (enc_dig),
        .value_o   (enc_val)
    );

    // Approximate mode: the lowest TRUNC_DIGITS digits are still emitted, but as zero.
    always_comb begin
        enc_kill = int'(enc_idx) < TRUNC_DIGITS;
        nxt_dig  = enc_kill ? '0 : enc_dig;
        nxt_val  = enc_kill ? 3'sd0 : enc_val;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        opnd_d    = opnd_q;
        dig_d     = dig_q;
        val_d     = val_q;
        last_d    = last_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                    idx_d   = '0;
                    opnd_d  = in_b;
                    dig_d   = nxt_dig;
                    val_d   = nxt_val;
                    last_d  = (enc_idx == LAST_IDX);
                end
            end
            RUN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        dig_d   = '0;
                        val_d   = 3'sd0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d   = enc_idx;
                        dig_d   = nxt_dig;
                        val_d   = nxt_val;
                        last_d  = (enc_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            opnd_q  <= '0;
            dig_q   <= '0;
            val_q   <= 3'sd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opnd_q  <= opnd_d;
            dig_q   <= dig_d;
            val_q   <= val_d;
            last_q  <= last_d;
        end
    end

    assign out_neg   = dig_q.neg;
    assign out_one   = dig_q.one;
    assign out_two   = dig_q.two;
    assign out_digit = val_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_booth_r4_enc_seq.sv
// Bench for booth_r4_enc_seq: an exact and a one-digit-truncated instance run
// in lock-step against a digit-queue model derived from the Booth recoding rule.
module tb_booth_r4_enc_seq;

    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic [WIDTH-1:0] in_b;
    logic out_ready;

    logic [1:0]       in_ready_w;
    logic [1:0]       out_valid_w;
    logic [1:0]       neg_w, one_w, two_w, last_w;
    logic [1:0][2:0]  digit_w;
    logic [1:0][1:0]  idx_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_r4_enc_seq #(.WIDTH(WIDTH), .TRUNC_DIGITS(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_b(in_b),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_neg(neg_w[0]), .out_one(one_w[0]), .out_two(two_w[0]),
        .out_digit(digit_w[0]), .out_idx(idx_w[0]), .out_last(last_w[0])
    );

    booth_r4_enc_seq #(.WIDTH(WIDTH), .TRUNC_DIGITS(1)) dut_trunc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_b(in_b),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_neg(neg_w[1]), .out_one(one_w[1]), .out_two(two_w[1]),
        .out_digit(digit_w[1]), .out_idx(idx_w[1]), .out_last(last_w[1])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Booth digit from the recoding rule: -2*b[2i+1] + b[2i] + b[2i-1], b[-1] = 0.
    function automatic int model_digit(input logic [WIDTH-1:0] b, input int i, input int trunc);
        logic [WIDTH:0] e;
        e = {b, 1'b0};
        if (i < trunc) return 0;
        return -2 * int'(e[2*i+2]) + int'(e[2*i+1]) + int'(e[2*i]);
    endfunction

    function automatic int model_sum(input logic [WIDTH-1:0] b, input int trunc);
        int s = 0;
        for (int i = 0; i < N; i++) s += model_digit(b, i, trunc) * (4 ** i);
        return s;
    endfunction

    typedef struct {
        int               d [2];
        int               idx;
        logic [WIDTH-1:0] b;
    } item_t;

    item_t mq[$];
    int    wsum;

    // Compare the current outputs with the model head, then predict the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            wsum = 0;
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rst_valid%0d", k), int'(out_valid_w[k]), 0);
                check($sformatf("rst_fields%0d", k),
                      int'({neg_w[k], one_w[k], two_w[k], digit_w[k], idx_w[k], last_w[k]}), 0);
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("valid%0d", k), int'(out_valid_w[k]), int'(mq.size() > 0));
                check($sformatf("ready%0d", k), int'(in_ready_w[k]), int'(mq.size() == 0));
                if (mq.size() > 0 && out_valid_w[k]) begin
                    int d;
                    d = mq[0].d[k];
                    check($sformatf("digit%0d_i%0d", k, mq[0].idx), int'($signed(digit_w[k])), d);
                    check($sformatf("idx%0d", k), int'(idx_w[k]), mq[0].idx);
                    check($sformatf("last%0d_i%0d", k, mq[0].idx), int'(last_w[k]), int'(mq[0].idx == N - 1));
                    check($sformatf("neg%0d_i%0d", k, mq[0].idx), int'(neg_w[k]), int'(d < 0));
                    check($sformatf("one%0d_i%0d", k, mq[0].idx), int'(one_w[k]), int'(d == 1 || d == -1));
                    check($sformatf("two%0d_i%0d", k, mq[0].idx), int'(two_w[k]), int'(d == 2 || d == -2));
                end
            end
            if (mq.size() == 0) begin
                if (in_valid) begin
                    for (int i = 0; i < N; i++) begin
                        item_t it;
                        it.d[0] = model_digit(in_b, i, 0);
                        it.d[1] = model_digit(in_b, i, 1);
                        it.idx  = i;
                        it.b    = in_b;
                        mq.push_back(it);
                    end
                end
            end else if (out_ready && out_valid_w[0]) begin
                wsum += int'($signed(digit_w[0])) * (4 ** int'(idx_w[0]));
                if (mq[0].idx == N - 1) begin
                    check("weighted_sum", wsum, int'($signed(mq[0].b)));
                    wsum = 0;
                end
                void'(mq.pop_front());
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 20 && !in_ready_w[0]; i++) @(posedge clk) #1;
        check("ready_timeout", int'(in_ready_w[0]), 1);
    endtask

    // Offer one operand for a single cycle, scramble in_b afterwards, and
    // optionally stall the consumer for stall cycles while digit 1 is shown.
    task automatic send(input logic [WIDTH-1:0] b, input int stall);
        wait_ready();
        in_valid = 1'b1;
        in_b     = b;
        @(posedge clk) #1;
        in_valid = 1'b0;
        in_b     = ~b;
        if (stall > 0) begin
            @(posedge clk) #1;
            out_ready = 1'b0;
            repeat (stall) @(posedge clk) #1;
            out_ready = 1'b1;
        end
        wait_ready();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("pin_7F_d0", model_digit(8'h7F, 0, 0), -1);
        check("pin_7F_d3", model_digit(8'h7F, 3, 0), 2);
        check("pin_80_d3", model_digit(8'h80, 3, 0), -2);
        check("pin_01_d0", model_digit(8'h01, 0, 0), 1);
        check("pin_7F_trunc_d0", model_digit(8'h7F, 0, 1), 0);
        check("pin_7F_sum", model_sum(8'h7F, 0), 127);
        check("pin_80_sum", model_sum(8'h80, 0), -128);
        check("pin_5A_sum", model_sum(8'h5A, 0), 90);

        send(8'h00, 0);
        send(8'h7F, 3);
        send(8'h80, 0);
        send(8'h7F, 0);
        send(8'hA5, 1);

        wait_ready();
        in_valid = 1'b1;
        in_b     = 8'h3C;
        repeat (12) begin
            @(posedge clk) #1;
            in_b = in_b + 8'h11;
        end
        in_valid = 1'b0;
        wait_ready();

        wait_ready();
        in_valid = 1'b1;
        in_b     = 8'h5A;
        @(posedge clk) #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk) #1;
        check("pre_rst_idx", int'(idx_w[0]), 2);
        rst_n = 1'b0;
        #1;
        check("rst_immediate_valid0", int'(out_valid_w[0]), 0);
        check("rst_immediate_valid1", int'(out_valid_w[1]), 0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", int'(in_ready_w[0]), 1);
        send(8'h01, 0);

        repeat (3) @(posedge clk);
        #1;
        check("model_drained", mq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_r4_enc_seq.md
BOOTH_R4_ENC_SEQ -- requirements
Module: booth_r4_enc_seq

Interface
REQ-001 Parameter WIDTH, default 8, multiplier operand width in bits; SHALL be even and >= 4.
REQ-002 Parameter TRUNC_DIGITS, default 0, count of least-significant Booth digits forced to zero for approximate operation; SHALL be in 0..WIDTH/2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand offered.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 in_b  input  WIDTH  signed two's-complement multiplier operand.
REQ-008 out_valid  output  1  digit fields valid.
REQ-009 out_ready  input  1  consumer accepts the digit.
REQ-010 out_neg  output  1  digit is negative; SHALL be 0 for a zero digit.
REQ-011 out_one  output  1  digit magnitude is 1.
REQ-012 out_two  output  1  digit magnitude is 2.
REQ-013 out_digit  output  3  signed digit value, -2..+2, consistent with neg/one/two.
REQ-014 out_idx  output  $clog2(WIDTH/2)  digit index, 0 = least significant.
REQ-015 out_last  output  1  high on the digit with index WIDTH/2-1.

Function
REQ-016 N = WIDTH/2 digits; digit i SHALL use triplet (b[2i+1], b[2i], b[2i-1]) with b[-1] = 0.
REQ-017 Digit value SHALL be -2*b[2i+1] + b[2i] + b[2i-1]; one = b[2i]^b[2i-1]; two = 1 only for triplets 100 and 011; neg = b[2i+1] & ~(b[2i] & b[2i-1]).
REQ-018 Digits with index < TRUNC_DIGITS SHALL be emitted with neg = one = two = 0 and out_digit = 0, and SHALL still be emitted in order.
REQ-019 FSM states IDLE and RUN.
REQ-020 IDLE: in_ready = 1 and out_valid = 0; on in_valid = 1, in_b is captured into an operand register, idx is cleared to 0, and the next state is RUN.
REQ-021 RUN: in_ready = 0 and out_valid = 1; the digit fields SHALL be driven from registers for the current idx.
REQ-022 Latency: an operand accepted at edge t SHALL present digit 0 with out_valid = 1 after edge t.
REQ-023 On out_valid & out_ready in RUN: if idx = N-1, the next state is IDLE; otherwise idx increments and the next digit appears after the same edge, giving one digit per cycle with no bubbles.
REQ-024 While out_valid = 1 and out_ready = 0, all out_* fields SHALL hold stable.
REQ-025 in_b changes while in RUN SHALL NOT affect the digits being emitted.
REQ-026 An operand SHALL NOT be accepted on the same edge as the last digit handshake; the next acceptance occurs at the earliest on the following edge, in IDLE.
REQ-027 The sum over i of out_digit(i) * 4^i SHALL equal signed in_b when TRUNC_DIGITS = 0.

Reset
REQ-028 rst_n = 0 SHALL immediately force state IDLE, idx = 0, operand register = 0, out_valid = 0, in_ready = 1 (after release), and out_neg/one/two/digit/idx/last = 0.
REQ-029 Reset asserted mid-RUN SHALL abandon the operand; no further digits of it are emitted.

Structure
REQ-030 Package booth_pkg SHALL hold the state enum (IDLE, RUN) and the struct booth_digit_t {neg, one, two}.
REQ-031 Triplet-to-digit encoding SHALL live in one combinational sub-module, booth_r4_digit_enc (inputs: 3-bit triplet; outputs: booth_digit_t and the 3-bit signed value), instantiated once on the idx-selected triplet.

Verification
REQ-032 WIDTH=8, in_b=8'h00, out_ready=1 -> 4 digits, all 0, out_idx 0..3, out_last only on idx 3, neg never 1.
REQ-033 in_b=8'h7F (127) -> digits -1, 0, 0, +2 (idx0 neg=1 one=1; idx3 two=1 neg=0); weighted sum 127.
REQ-034 in_b=8'h80 (-128) -> digits 0, 0, 0, -2 (idx3 neg=1 two=1); weighted sum -128.
REQ-035 in_b=8'h7F with out_ready low for 3 cycles while idx=1 -> idx1 fields held constant for 4 cycles and in_ready=0 throughout; idx2 follows on the first handshake.
REQ-036 TRUNC_DIGITS=1, in_b=8'h7F -> idx0 emitted as 0 with neg=one=two=0; remaining digits 0, 0, +2.
REQ-037 Assert rst_n=0 during idx2 of in_b=8'h5A -> out_valid=0 immediately; after release in_ready=1, and a new operand 8'h01 yields digits +1, 0, 0, 0.
